// File: rtl/edge_event_detector.sv
// rtl/edge_event_detector.sv - multi-channel synchronised edge detector with sticky pending flags and event port
module edge_event_detector #(
    parameter int CHANNELS    = 4,
    parameter int SYNC_STAGES = 2,
    parameter int IDX_W       = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [CHANNELS-1:0]     in_i,
    input  logic [2*CHANNELS-1:0]   mode_i,
    output logic [CHANNELS-1:0]     pulse_o,
    output logic [CHANNELS-1:0]     pending_o,
    output logic [CHANNELS-1:0]     overflow_o,
    input  logic                    ovf_clr_i,
    output logic                    evt_valid_o,
    output logic [IDX_W-1:0]        evt_idx_o,
    input  logic                    evt_ready_i
);

    typedef enum logic {S_IDLE, S_OFFER} state_t;

    logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q;
    logic [CHANNELS-1:0] hist_q;
    logic [CHANNELS-1:0] last;
    logic [CHANNELS-1:0] pulse;
    logic [CHANNELS-1:0] clr_mask;
    logic [CHANNELS-1:0] pending_q, pending_d;
    logic [CHANNELS-1:0] overflow_q, overflow_d;
    logic [IDX_W-1:0]    lowest;
    logic [IDX_W-1:0]    idx_q, idx_d;
    state_t              state_q, state_d;

    // Chain and history run regardless of mode so a mode change never fakes an edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
            hist_q <= '0;
        end else begin
            sync_q[0] <= in_i;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
            hist_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign last = sync_q[SYNC_STAGES-1];

    always_comb begin
        pulse = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            case ({mode_i[2*c+1], mode_i[2*c]})
                2'b01:   pulse[c] = last[c] & ~hist_q[c];
                2'b10:   pulse[c] = ~last[c] & hist_q[c];
                2'b11:   pulse[c] = last[c] ^ hist_q[c];
                default: pulse[c] = 1'b0;
            endcase
        end
    end

    always_comb begin
        clr_mask = '0;
        if (state_q == S_OFFER && evt_ready_i) begin
            clr_mask[idx_q] = 1'b1;
        end
    end

    // A new edge on the channel being accepted re-arms pending without counting as overflow.
    always_comb begin
        pending_d  = (pending_q & ~clr_mask) | pulse;
        overflow_d = (ovf_clr_i ? '0 : overflow_q) | (pulse & pending_q & ~clr_mask);
    end

    always_comb begin
        lowest = '0;
        for (int c = CHANNELS - 1; c >= 0; c--) begin
            if (pending_q[c]) begin
                lowest = IDX_W'(c);
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        evt_valid_o = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pending_q != '0) begin
                    idx_d   = lowest;
                    state_d = S_OFFER;
                end
            end
            S_OFFER: begin
                evt_valid_o = 1'b1;
                if (evt_ready_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pending_q  <= '0;
            overflow_q <= '0;
            idx_q      <= '0;
            state_q    <= S_IDLE;
        end else begin
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
            idx_q      <= idx_d;
            state_q    <= state_d;
        end
    end

    assign pulse_o    = pulse;
    assign pending_o  = pending_q;
    assign overflow_o = overflow_q;
    assign evt_idx_o  = idx_q;

endmodule

// File: tb/tb_edge_event_detector.sv
// tb/tb_edge_event_detector.sv - vector table, corner sequences and random run against a trace-based model
module tb_edge_event_detector;

    localparam int SS = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] in_r = '0;
    logic [7:0] mode_r = '0;
    logic       ovf_clr = 1'b0;
    logic       evt_ready = 1'b0;
    logic [3:0] pulse, pending, overflow;
    logic       evt_valid;
    logic [1:0] evt_idx;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    edge_event_detector #(.CHANNELS(4), .SYNC_STAGES(SS), .IDX_W(2)) dut (
        .clk(clk), .reset(reset), .in_i(in_r), .mode_i(mode_r),
        .pulse_o(pulse), .pending_o(pending), .overflow_o(overflow),
        .ovf_clr_i(ovf_clr), .evt_valid_o(evt_valid), .evt_idx_o(evt_idx),
        .evt_ready_i(evt_ready)
    );

    // Model: every input level sampled since reset, plus pending/overflow sets and the offered channel.
    logic [3:0] trace[$];
    logic [3:0] m_pend, m_ovf;
    int         m_off = -1;

    function automatic logic [3:0] lvl(input int j);
        if (j >= 1 && j <= trace.size()) return trace[j-1];
        return 4'h0;
    endfunction

    function automatic logic [3:0] model_pulse();
        logic [3:0] cur, prev, p;
        int k;
        k = trace.size();
        cur = lvl(k - SS + 1);
        prev = lvl(k - SS);
        p = '0;
        for (int c = 0; c < 4; c++) begin
            case (mode_r[2*c +: 2])
                2'b01: p[c] = cur[c] && !prev[c];
                2'b10: p[c] = !cur[c] && prev[c];
                2'b11: p[c] = cur[c] != prev[c];
                default: p[c] = 1'b0;
            endcase
        end
        return p;
    endfunction

    task automatic model_update(input logic [3:0] p);
        logic [3:0] clr;
        int nxt;
        if (reset) begin
            trace.delete();
            m_pend = '0;
            m_ovf = '0;
            m_off = -1;
        end else begin
            clr = (m_off >= 0 && evt_ready) ? 4'(1 << m_off) : 4'h0;
            nxt = m_off;
            if (m_off >= 0) begin
                if (evt_ready) nxt = -1;
            end else if (m_pend != 0) begin
                for (int c = 3; c >= 0; c--) if (m_pend[c]) nxt = c;
            end
            m_ovf = (ovf_clr ? 4'h0 : m_ovf) | (p & m_pend & ~clr);
            m_pend = (m_pend & ~clr) | p;
            m_off = nxt;
            trace.push_back(in_r);
        end
    endtask

    task automatic step();
        logic [3:0] p;
        p = model_pulse();
        @(posedge clk);
        model_update(p);
        @(negedge clk);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_model();
        chk("rnd_pulse", 32'(pulse), 32'(model_pulse()));
        chk("rnd_pending", 32'(pending), 32'(m_pend));
        chk("rnd_overflow", 32'(overflow), 32'(m_ovf));
        chk("rnd_valid", 32'(evt_valid), 32'(m_off >= 0));
        if (m_off >= 0) chk("rnd_idx", 32'(evt_idx), 32'(m_off));
    endtask

    task automatic do_reset(input logic [3:0] lvl_in);
        reset = 1'b1;
        in_r = lvl_in;
        evt_ready = 1'b0;
        ovf_clr = 1'b0;
        step();
        step();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [3:0] in;
        logic [7:0] mode;
        logic       rdy;
        logic [3:0] pulse;
        logic [3:0] pend;
        logic       valid;
        logic [1:0] idx;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int cnt[4];
        int seen;

        tbl[0] = '{4'h1, 8'h01, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0};
        tbl[1] = '{4'h1, 8'h01, 1'b0, 4'h1, 4'h0, 1'b0, 2'd0};
        tbl[2] = '{4'h1, 8'h01, 1'b0, 4'h0, 4'h1, 1'b0, 2'd0};
        tbl[3] = '{4'h1, 8'h01, 1'b0, 4'h0, 4'h1, 1'b1, 2'd0};
        tbl[4] = '{4'h1, 8'h01, 1'b1, 4'h0, 4'h0, 1'b0, 2'd0};
        tbl[5] = '{4'h1, 8'h01, 1'b0, 4'h0, 4'h0, 1'b0, 2'd0};

        do_reset(4'h0);
        chk("rst_pulse", 32'(pulse), 0);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_overflow", 32'(overflow), 0);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_idx", 32'(evt_idx), 0);

        // Rise on ch0: pulse, pending, offer, accept.
        for (int i = 0; i < 6; i++) begin
            in_r = tbl[i].in;
            mode_r = tbl[i].mode;
            evt_ready = tbl[i].rdy;
            step();
            chk($sformatf("vec%0d_pulse", i), 32'(pulse), 32'(tbl[i].pulse));
            chk($sformatf("vec%0d_pending", i), 32'(pending), 32'(tbl[i].pend));
            chk($sformatf("vec%0d_valid", i), 32'(evt_valid), 32'(tbl[i].valid));
            if (tbl[i].valid) chk($sformatf("vec%0d_idx", i), 32'(evt_idx), 32'(tbl[i].idx));
        end

        // Modes: ch1 off, ch2 fall, ch3 both.
        mode_r = 8'hE0;
        do_reset(4'h0);
        evt_ready = 1'b1;
        cnt = '{0, 0, 0, 0};
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            in_r = (i < 4) ? 4'hE : 4'h0;
            step();
            for (int c = 0; c < 4; c++) cnt[c] += int'(pulse[c]);
            seen += int'(pending[1]);
        end
        chk("mode_off_pulses", 32'(cnt[1]), 0);
        chk("mode_off_pending", 32'(seen), 0);
        chk("mode_fall_pulses", 32'(cnt[2]), 1);
        chk("mode_both_pulses", 32'(cnt[3]), 2);

        // Offered index is held; lower channel waits its turn.
        mode_r = 8'h55;
        do_reset(4'h0);
        in_r = 4'hA;
        repeat (4) step();
        chk("hold_valid0", 32'(evt_valid), 1);
        chk("hold_idx0", 32'(evt_idx), 1);
        in_r = 4'hB;
        repeat (5) step();
        chk("hold_idx5", 32'(evt_idx), 1);
        chk("hold_pending", 32'(pending), 32'hB);
        evt_ready = 1'b1;
        step();
        chk("bubble_valid", 32'(evt_valid), 0);
        evt_ready = 1'b0;
        step();
        chk("next_valid", 32'(evt_valid), 1);
        chk("next_idx0", 32'(evt_idx), 0);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        step();
        chk("last_idx3", 32'(evt_idx), 3);
        chk("last_pending", 32'(pending), 32'h8);

        // Overflow, ovf_clr, and re-arm coinciding with accept.
        mode_r = 8'h01;
        do_reset(4'h0);
        in_r = 4'h1;
        repeat (4) step();
        in_r = 4'h0;
        repeat (3) step();
        in_r = 4'h1;
        repeat (3) step();
        chk("ovf_set", 32'(overflow), 1);
        chk("ovf_pending", 32'(pending), 1);
        ovf_clr = 1'b1;
        step();
        ovf_clr = 1'b0;
        chk("ovf_clr", 32'(overflow), 0);
        in_r = 4'h0;
        repeat (3) step();
        in_r = 4'h1;
        step();
        step();
        chk("coin_pulse", 32'(pulse), 1);
        evt_ready = 1'b1;
        step();
        evt_ready = 1'b0;
        chk("coin_pending", 32'(pending), 1);
        chk("coin_overflow", 32'(overflow), 0);
        chk("coin_valid", 32'(evt_valid), 0);
        step();
        chk("coin_reoffer", 32'(evt_valid), 1);

        // Level high through reset release, then reset mid-offer.
        mode_r = 8'h55;
        do_reset(4'h2);
        step();
        chk("relhi_pulse1", 32'(pulse), 0);
        step();
        chk("relhi_pulse2", 32'(pulse), 2);
        step();
        step();
        chk("relhi_valid", 32'(evt_valid), 1);
        chk("relhi_idx", 32'(evt_idx), 1);
        reset = 1'b1;
        step();
        chk("midrst_outs", {pulse, pending, overflow, 3'(evt_valid), 2'(evt_idx)}, 0);
        in_r = 4'h0;
        reset = 1'b0;
        seen = 0;
        repeat (6) begin
            step();
            seen += int'(evt_valid);
        end
        chk("midrst_no_reoffer", 32'(seen), 0);

        // Randomised run against the model.
        do_reset(4'h0);
        for (int i = 0; i < 3000; i++) begin
            if (i % 64 == 0) mode_r = 8'($urandom);
            for (int c = 0; c < 4; c++) if ($urandom_range(3) == 0) in_r[c] = ~in_r[c];
            evt_ready = 1'($urandom);
            ovf_clr = ($urandom_range(7) == 0);
            reset = ($urandom_range(299) == 0);
            step();
            check_model();
        end
        reset = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
